// File: rtl/simd_reg_file.sv
// SIMD register file: scalar and vector banks, two combinational read ports with
// write bypass, a per-register pending scoreboard and a sequential bulk-clear sweep.
module simd_reg_file #(
   parameter int unsigned REG_SIZE   = 16,
   parameter int unsigned VEC_SIZE   = 4,
   parameter int unsigned SCALAR_QTY = 16,
   parameter int unsigned VECTOR_QTY = 8,
   parameter int unsigned SEL_BITS   = 5
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [SEL_BITS-1:0]                rSel1,
   input  logic [SEL_BITS-1:0]                rSel2,
   output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  operand1,
   output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  operand2,
   output logic                               rdPend1,
   output logic                               rdPend2,
   input  logic                               wrValid,
   output logic                               wrReady,
   input  logic [SEL_BITS-1:0]                wrSel,
   input  logic [VEC_SIZE-1:0]                wrMask,
   input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  dataIn,
   input  logic                               markEn,
   input  logic [SEL_BITS-1:0]                markSel,
   input  logic                               clrReq,
   output logic                               busy,
   output logic                               clrDone
);

   localparam int unsigned IDX_W   = SEL_BITS - 1;
   localparam int unsigned MAX_QTY = (SCALAR_QTY > VECTOR_QTY) ? SCALAR_QTY : VECTOR_QTY;
   localparam int unsigned CNT_W   = $clog2(MAX_QTY + 1);

   typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic [CNT_W-1:0]      r_cnt;
   vec_t                  r_vec [VECTOR_QTY];
   logic [REG_SIZE-1:0]   r_sca [SCALAR_QTY];
   logic [VECTOR_QTY-1:0] r_vpend;
   logic [SCALAR_QTY-1:0] r_spend;

   logic w_wr;
   logic w_mark;

   assign w_wr    = wrValid & ~r_busy;
   assign w_mark  = markEn & ~r_busy;
   assign wrReady = ~r_busy;
   assign busy    = r_busy;
   assign clrDone = r_done;

   // Read mux with same-cycle bypass of an accepted write; out-of-range reads return 0.
   function automatic vec_t f_read(input logic [SEL_BITS-1:0] sel);
      vec_t             v;
      logic [IDX_W-1:0] idx;
      v   = '0;
      idx = sel[IDX_W-1:0];
      if (sel[SEL_BITS-1]) begin
         for (int unsigned i = 0; i < SCALAR_QTY; i++)
            if (32'(idx) == i)
               for (int unsigned l = 0; l < VEC_SIZE; l++) v[l] = r_sca[i];
         if (w_wr && (wrSel == sel) && (32'(idx) < SCALAR_QTY))
            for (int unsigned l = 0; l < VEC_SIZE; l++) v[l] = dataIn[0];
      end else begin
         for (int unsigned i = 0; i < VECTOR_QTY; i++)
            if (32'(idx) == i) v = r_vec[i];
         if (w_wr && (wrSel == sel) && (32'(idx) < VECTOR_QTY))
            for (int unsigned l = 0; l < VEC_SIZE; l++)
               if (wrMask[l]) v[l] = dataIn[l];
      end
      return v;
   endfunction

   function automatic logic f_pend(input logic [SEL_BITS-1:0] sel);
      logic p;
      p = 1'b0;
      for (int unsigned i = 0; i < MAX_QTY; i++)
         if (32'(sel[IDX_W-1:0]) == i) begin
            if (sel[SEL_BITS-1] && (i < SCALAR_QTY))       p = r_spend[i];
            else if (!sel[SEL_BITS-1] && (i < VECTOR_QTY)) p = r_vpend[i];
         end
      return p;
   endfunction

   always_comb begin
      operand1 = f_read(rSel1);
      operand2 = f_read(rSel2);
      rdPend1  = f_pend(rSel1);
      rdPend2  = f_pend(rSel2);
   end

   // Bulk-clear sequencer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (clrReq) begin
                  r_state <= ST_CLEAR;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            ST_CLEAR: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(MAX_QTY - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Register banks and scoreboard; a mark issued with a write to the same register wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < VECTOR_QTY; i++) r_vec[i] <= '0;
         for (int unsigned i = 0; i < SCALAR_QTY; i++) r_sca[i] <= '0;
         r_vpend <= '0;
         r_spend <= '0;
      end else begin
         for (int unsigned i = 0; i < VECTOR_QTY; i++) begin
            if (r_busy && (32'(r_cnt) == i)) begin
               r_vec[i]   <= '0;
               r_vpend[i] <= 1'b0;
            end else begin
               if (w_wr && !wrSel[SEL_BITS-1] && (32'(wrSel[IDX_W-1:0]) == i)) begin
                  for (int unsigned l = 0; l < VEC_SIZE; l++)
                     if (wrMask[l]) r_vec[i][l] <= dataIn[l];
                  r_vpend[i] <= 1'b0;
               end
               if (w_mark && !markSel[SEL_BITS-1] && (32'(markSel[IDX_W-1:0]) == i))
                  r_vpend[i] <= 1'b1;
            end
         end
         for (int unsigned i = 0; i < SCALAR_QTY; i++) begin
            if (r_busy && (32'(r_cnt) == i)) begin
               r_sca[i]   <= '0;
               r_spend[i] <= 1'b0;
            end else begin
               if (w_wr && wrSel[SEL_BITS-1] && (32'(wrSel[IDX_W-1:0]) == i)) begin
                  r_sca[i]   <= dataIn[0];
                  r_spend[i] <= 1'b0;
               end
               if (w_mark && markSel[SEL_BITS-1] && (32'(markSel[IDX_W-1:0]) == i))
                  r_spend[i] <= 1'b1;
            end
         end
      end
   end

endmodule
